// File: rtl/jtframe_sdram_sched_pkg.sv
// Shared types and helpers for the SDRAM round-robin scheduler.
package jtframe_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] WRMASK_IDLE = 2'b11;

    // Next slot index with explicit wrap so non-power-of-2 slot counts work.
    function automatic int rr_next(input int idx, input int slots);
        return (idx >= slots - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/jtframe_sdram_sched_if.sv
// Game-side SDRAM port between the scheduler (master) and the board controller (slave).
interface jtframe_sdram_sched_if #(
    parameter int AW = 22
);
    logic          sdram_req;
    logic          sdram_ack;
    logic [AW-1:0] sdram_addr;
    logic [1:0]    sdram_bank;
    logic          sdram_rnw;
    logic [1:0]    sdram_wrmask;
    logic [15:0]   data_write;
    logic [31:0]   data_read;
    logic          data_rdy;

    modport master (
        output sdram_req, sdram_addr, sdram_bank, sdram_rnw, sdram_wrmask, data_write,
        input  sdram_ack, data_read, data_rdy
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_bank, sdram_rnw, sdram_wrmask, data_write,
        output sdram_ack, data_read, data_rdy
    );
endinterface

// File: rtl/jtframe_sdram_sched_rr_pick.sv
// Combinational next-grant finder: first requester at or after ptr, with wrap-around.
// When prio is set, req[0] wins outright regardless of the pointer.
module jtframe_rr_pick #(
    parameter int SLOTS = 4,
    parameter int PW    = 2
) (
    input  logic [SLOTS-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             prio,
    output logic [PW-1:0]    idx,
    output logic             valid
);
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        if (prio && req[0]) begin
            valid = 1'b1;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                sum = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= (PW+1)'(SLOTS)) begin
                    sum = sum - (PW+1)'(SLOTS);
                end
                cand = sum[PW-1:0];
                if (!valid && req[cand]) begin
                    valid = 1'b1;
                    idx   = cand;
                end
            end
        end
    end
endmodule

// File: rtl/jtframe_sdram_sched.sv
// Round-robin scheduler sharing one SDRAM port among SLOTS requesters.
// Define JTFRAME_SDRAM_SCHED_PRIO_EN to give slot 0 fixed absolute priority.
module jtframe_sdram_sched
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS    = 4,
    parameter int AW       = 22,
    parameter int RR_START = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [SLOTS-1:0]   slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS*2-1:0] slot_bank,
    input  logic [SLOTS-1:0]   slot_rnw,
    input  logic [SLOTS*2-1:0] slot_wrmask,
    input  logic [SLOTS*16-1:0] slot_din,
    output logic [SLOTS-1:0]   slot_ack,
    output logic [SLOTS-1:0]   slot_rdy,
    output logic [31:0]        slot_dout,
    output logic               busy,
    jtframe_sdram_sched_if.master sdram
);
    localparam int PW = $clog2(SLOTS);

`ifdef JTFRAME_SDRAM_SCHED_PRIO_EN
    localparam logic PRIO = 1'b1;
`else
    localparam logic PRIO = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick_idx;
    logic          pick_valid;
    logic          req_q, req_d, rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    bank_q, bank_d, wrmask_q, wrmask_d;
    logic [15:0]   din_q, din_d;
    logic [SLOTS-1:0] ack_q, ack_d, rdy_q, rdy_d;
    logic [31:0]   dout_q, dout_d;

    jtframe_rr_pick #(.SLOTS(SLOTS), .PW(PW)) u_pick (
        .req   (slot_req),
        .ptr   (ptr_q),
        .prio  (PRIO),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        req_d    = req_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        wrmask_d = wrmask_q;
        din_d    = din_q;
        dout_d   = dout_q;
        ack_d    = '0;
        rdy_d    = '0;
        case (state_q)
            IDLE: begin
                if (!downloading && pick_valid) begin
                    gnt_d    = pick_idx;
                    addr_d   = slot_addr[pick_idx*AW +: AW];
                    bank_d   = slot_bank[pick_idx*2 +: 2];
                    rnw_d    = slot_rnw[pick_idx];
                    wrmask_d = slot_wrmask[pick_idx*2 +: 2];
                    din_d    = slot_din[pick_idx*16 +: 16];
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (sdram.sdram_ack) begin
                    req_d        = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (sdram.data_rdy) begin
                    dout_d       = sdram.data_read;
                    rdy_d[gnt_q] = 1'b1;
                    // Slot 0 grants under fixed priority leave the rotation untouched.
                    if (!(PRIO && gnt_q == '0)) begin
                        ptr_d = PW'(rr_next(int'(gnt_q), SLOTS));
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(RR_START);
            gnt_q    <= '0;
            req_q    <= 1'b0;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            bank_q   <= '0;
            wrmask_q <= WRMASK_IDLE;
            din_q    <= '0;
            dout_q   <= '0;
            ack_q    <= '0;
            rdy_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            req_q    <= req_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            wrmask_q <= wrmask_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
        end
    end

    assign sdram.sdram_req    = req_q;
    assign sdram.sdram_addr   = addr_q;
    assign sdram.sdram_bank   = bank_q;
    assign sdram.sdram_rnw    = rnw_q;
    assign sdram.sdram_wrmask = wrmask_q;
    assign sdram.data_write   = din_q;
    assign slot_ack  = ack_q;
    assign slot_rdy  = rdy_q;
    assign slot_dout = dout_q;
    assign busy      = (state_q != IDLE);
endmodule
